// File: rtl/spr_ram_pkg.sv
// rtl/spr_ram_pkg.sv - command encodings and FSM states for the burst RAM
package spr_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR  = 2'b00;
  localparam logic [1:0] CMD_WR_DATA  = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR  = 2'b10;
  localparam logic [1:0] CMD_RD_BURST = 2'b11;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } spr_state_e;

endpackage

// File: rtl/spr_mem_core.sv
// rtl/spr_mem_core.sv - storage array: synchronous write, combinational read index
module spr_mem_core #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/spr_cmd_ram_burst.sv
// rtl/spr_cmd_ram_burst.sv - command-driven RAM with read bursts; optional parity via SPR_RAM_PARITY_EN
module spr_cmd_ram_burst
  import spr_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W+1:0] din,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              busy
`ifdef SPR_RAM_PARITY_EN
  ,
  output logic              par_err
`endif
);

`ifdef SPR_RAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int MEM_W = DATA_W + PAR_W;

  spr_state_e        state_q;
  logic [ADDR_W-1:0] addr_wr_q;
  logic [ADDR_W-1:0] addr_rd_q;
  logic [DATA_W-1:0] remaining_q;
  logic [DATA_W-1:0] dout_q;
  logic              tx_valid_q;

  logic [1:0]        cmd;
  logic [DATA_W-1:0] payload;
  logic              accept;
  logic              wr_en;
  logic [MEM_W-1:0]  wr_word;
  logic [ADDR_W-1:0] rd_idx_d;
  logic [MEM_W-1:0]  rd_word;

  assign cmd     = din[DATA_W+1:DATA_W];
  assign payload = din[DATA_W-1:0];
  assign accept  = rx_valid && (state_q == S_IDLE);
  assign wr_en   = accept && (cmd == CMD_WR_DATA);

`ifdef SPR_RAM_PARITY_EN
  assign wr_word = {^payload, payload};
`else
  assign wr_word = payload;
`endif

  // In BURST the next word to load is always one past the word being handed off.
  assign rd_idx_d = (state_q == S_BURST) ? addr_rd_q + ADDR_W'(1) : addr_rd_q;

  spr_mem_core #(
    .WIDTH  (MEM_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (addr_wr_q),
    .wr_data_i (wr_word),
    .rd_addr_i (rd_idx_d),
    .rd_data_o (rd_word)
  );

`ifdef SPR_RAM_PARITY_EN
  logic par_err_q;
  assign par_err = par_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if ((state_q == S_IDLE && accept && cmd == CMD_RD_BURST) ||
                 (state_q == S_BURST && tx_valid_q && tx_ready && remaining_q != '0)) begin
      par_err_q <= ^rd_word;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_wr_q   <= '0;
      addr_rd_q   <= '0;
      remaining_q <= '0;
      dout_q      <= '0;
      tx_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (cmd)
              CMD_WR_ADDR: addr_wr_q <= payload[ADDR_W-1:0];
              CMD_WR_DATA: begin
                if (AUTO_INC != 0) begin
                  addr_wr_q <= addr_wr_q + ADDR_W'(1);
                end
              end
              CMD_RD_ADDR: addr_rd_q <= payload[ADDR_W-1:0];
              default: begin
                remaining_q <= payload;
                dout_q      <= rd_word[DATA_W-1:0];
                tx_valid_q  <= 1'b1;
                state_q     <= S_BURST;
              end
            endcase
          end
        end
        S_BURST: begin
          if (tx_valid_q && tx_ready) begin
            addr_rd_q <= addr_rd_q + ADDR_W'(1);
            if (remaining_q != '0) begin
              remaining_q <= remaining_q - DATA_W'(1);
              dout_q      <= rd_word[DATA_W-1:0];
            end else begin
              tx_valid_q <= 1'b0;
              state_q    <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_ready = (state_q == S_IDLE);
  assign busy     = (state_q == S_BURST);
  assign tx_valid = tx_valid_q;
  assign dout     = dout_q;

endmodule

// File: tb/tb_spr_cmd_ram_burst.sv
// tb/tb_spr_cmd_ram_burst.sv - directed bench for spr_cmd_ram_burst; parity steps under SPR_RAM_PARITY_EN
module tb_spr_cmd_ram_burst;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic       rx_ready;
  logic [9:0] din;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] dout;
  logic       busy;
`ifdef SPR_RAM_PARITY_EN
  logic       par_err;
`endif

  int vectors;
  int miscompares;

  spr_cmd_ram_burst #(
    .DATA_W   (8),
    .ADDR_W   (8),
    .AUTO_INC (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .din      (din),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .dout     (dout),
    .busy     (busy)
`ifdef SPR_RAM_PARITY_EN
    ,
    .par_err  (par_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; the frame is accepted on the following posedge.
  task automatic send(input logic [1:0] cmd, input logic [7:0] payload);
    rx_valid = 1'b1;
    din      = {cmd, payload};
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    rx_valid    = 1'b0;
    tx_ready    = 1'b0;
    din         = '0;
    repeat (2) @(negedge clk);

    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rx_ready", 32'(rx_ready), 32'h1);
    chk("rst_dout", 32'(dout), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // single write then single-word read
    tx_ready = 1'b1;
    send(2'b00, 8'h10);
    send(2'b01, 8'hA5);
    send(2'b10, 8'h10);
    send(2'b11, 8'h00);
    chk("single_tx_valid", 32'(tx_valid), 32'h1);
    chk("single_dout", 32'(dout), 32'hA5);
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_rx_ready", 32'(rx_ready), 32'h0);
    @(negedge clk);
    chk("single_end_tx_valid", 32'(tx_valid), 32'h0);
    chk("single_end_busy", 32'(busy), 32'h0);
    chk("single_addr_rd", 32'(dut.addr_rd_q), 32'h11);

    // auto-increment writes, three-word burst without backpressure
    send(2'b00, 8'h20);
    send(2'b01, 8'h01);
    send(2'b01, 8'h02);
    send(2'b01, 8'h03);
    send(2'b10, 8'h20);
    send(2'b11, 8'h02);
    chk("burst_w0", 32'(dout), 32'h01);
    chk("burst_v0", 32'(tx_valid), 32'h1);
    @(negedge clk);
    chk("burst_w1", 32'(dout), 32'h02);
    chk("burst_v1", 32'(tx_valid), 32'h1);
    @(negedge clk);
    chk("burst_w2", 32'(dout), 32'h03);
    chk("burst_v2", 32'(tx_valid), 32'h1);
    @(negedge clk);
    chk("burst_end_tx_valid", 32'(tx_valid), 32'h0);
    chk("burst_end_busy", 32'(busy), 32'h0);
    chk("burst_end_addr_rd", 32'(dut.addr_rd_q), 32'h23);

    // backpressure on the second word
    send(2'b10, 8'h20);
    send(2'b11, 8'h02);
    chk("bp_w0", 32'(dout), 32'h01);
    @(negedge clk);
    chk("bp_w1", 32'(dout), 32'h02);
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold_dout", 32'(dout), 32'h02);
      chk("bp_hold_valid", 32'(tx_valid), 32'h1);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    chk("bp_w2", 32'(dout), 32'h03);
    @(negedge clk);
    chk("bp_end_tx_valid", 32'(tx_valid), 32'h0);

    // address wrap on write and read
    send(2'b00, 8'hFF);
    send(2'b01, 8'h11);
    send(2'b01, 8'h22);
    chk("wrap_addr_wr", 32'(dut.addr_wr_q), 32'h01);
    send(2'b10, 8'hFF);
    send(2'b11, 8'h01);
    chk("wrap_w0", 32'(dout), 32'h11);
    @(negedge clk);
    chk("wrap_w1", 32'(dout), 32'h22);
    @(negedge clk);
    chk("wrap_end_tx_valid", 32'(tx_valid), 32'h0);
    chk("wrap_addr_rd", 32'(dut.addr_rd_q), 32'h01);

    // frames offered during a burst are ignored
    tx_ready = 1'b0;
    send(2'b10, 8'h20);
    send(2'b11, 8'h02);
    rx_valid = 1'b1;
    din      = {2'b00, 8'h55};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("blk_rx_ready", 32'(rx_ready), 32'h0);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("blk_end_busy", 32'(busy), 32'h0);
    chk("blk_addr_wr", 32'(dut.addr_wr_q), 32'h01);
    send(2'b01, 8'h77);
    send(2'b10, 8'h01);
    send(2'b11, 8'h00);
    chk("blk_readback", 32'(dout), 32'h77);
    @(negedge clk);

    // reset in the middle of a burst
    send(2'b10, 8'h20);
    send(2'b11, 8'h02);
    chk("rstmid_w0", 32'(dout), 32'h01);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_tx_valid", 32'(tx_valid), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_rx_ready", 32'(rx_ready), 32'h1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_still_idle", 32'(tx_valid), 32'h0);
    send(2'b10, 8'h20);
    send(2'b11, 8'h02);
    chk("rstmid_keep0", 32'(dout), 32'h01);
    @(negedge clk);
    chk("rstmid_keep1", 32'(dout), 32'h02);
    @(negedge clk);
    chk("rstmid_keep2", 32'(dout), 32'h03);
    @(negedge clk);
    chk("rstmid_done", 32'(tx_valid), 32'h0);

`ifdef SPR_RAM_PARITY_EN
    // corrupt one stored parity bit
    send(2'b00, 8'h30);
    send(2'b01, 8'h5A);
    send(2'b01, 8'h5B);
    dut.u_mem.mem_q[8'h30][8] = ~dut.u_mem.mem_q[8'h30][8];
    send(2'b10, 8'h30);
    send(2'b11, 8'h01);
    chk("par_w0", 32'(dout), 32'h5A);
    chk("par_err_bad", 32'(par_err), 32'h1);
    @(negedge clk);
    chk("par_w1", 32'(dout), 32'h5B);
    chk("par_err_clean", 32'(par_err), 32'h0);
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
